// File: rtl/regfile_scb.sv
// Register file with a per-register busy scoreboard: combinational reads with
// same-cycle writeback bypass, issue gating on operand/destination readiness.
module regfile_scb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rdy1,
    output logic            rdy2,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_en;
    logic             set_en;
    logic             fire;
    logic             dst_ok;
    logic             inc;
    logic             dec;

    assign wr_en = we3 && (a3 != '0);

    // Read ports: x0 forced to zero, writeback data bypassed onto a matching read.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (a1 != '0) rd1 = (we3 && a3 == a1) ? wd3 : mem[a1];
        if (a2 != '0) rd2 = (we3 && a3 == a2) ? wd3 : mem[a2];
    end

    assign rdy1   = (a1 == '0) || !busy[a1] || (we3 && a3 == a1);
    assign rdy2   = (a2 == '0) || !busy[a2] || (we3 && a3 == a2);
    assign dst_ok = (iss_rd == '0) || !busy[iss_rd] || (we3 && a3 == iss_rd);

    assign iss_ready = rdy1 && rdy2 && dst_ok;
    assign fire      = iss_valid && iss_ready;
    assign set_en    = fire && (iss_rd != '0);

    // Clear first, then set, so an issue to the register being written back wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)  busy_nxt[a3]     = 1'b0;
        if (set_en) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign inc = set_en && !busy[iss_rd];
    assign dec = wr_en && busy[a3] && !(set_en && iss_rd == a3);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en) mem[a3] <= wd3;
            busy <= busy_nxt;
            case ({inc, dec})
                2'b10:   busy_cnt <= busy_cnt + (AW+1)'(1);
                2'b01:   busy_cnt <= busy_cnt - (AW+1)'(1);
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scb.sv
// Bench for regfile_scb: directed scenarios plus random traffic, all checked
// against an array-based architectural model of registers and busy flags.
module tb_regfile_scb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   a1, a2, a3, iss_rd;
    logic [XLEN-1:0] rd1, rd2, wd3;
    logic            rdy1, rdy2, we3, iss_valid, iss_ready;
    logic [AW:0]     busy_cnt;

    regfile_scb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset),
        .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .rdy1(rdy1), .rdy2(rdy2),
        .we3(we3), .a3(a3), .wd3(wd3),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    // Architectural model
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] m_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we3 && a3 == a) return wd3;
        return m_mem[a];
    endfunction

    function automatic bit m_rdy(input logic [AW-1:0] a);
        return (a == 0) || !m_busy[a] || (we3 && a3 == a);
    endfunction

    function automatic bit m_iss_ready();
        return m_rdy(a1) && m_rdy(a2) && m_rdy(iss_rd);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic drive(input bit r, input int x1, input int x2, input bit we,
                         input int x3, input logic [XLEN-1:0] wd, input bit iv, input int ird);
        reset = r; a1 = AW'(x1); a2 = AW'(x2); we3 = we; a3 = AW'(x3);
        wd3 = wd; iss_valid = iv; iss_rd = AW'(ird);
    endtask

    // Compare every output against the model, 1 time unit after inputs settle.
    task automatic check_all(input string tag);
        #1;
        chk({tag, ".rd1"},  64'(rd1),  64'(m_rd(a1)));
        chk({tag, ".rd2"},  64'(rd2),  64'(m_rd(a2)));
        chk({tag, ".rdy1"}, 64'(rdy1), 64'(m_rdy(a1)));
        chk({tag, ".rdy2"}, 64'(rdy2), 64'(m_rdy(a2)));
        chk({tag, ".iss_ready"}, 64'(iss_ready), 64'(m_iss_ready()));
        chk({tag, ".busy_cnt"},  64'(busy_cnt),  64'(m_count()));
    endtask

    // Advance one clock, applying the architectural rules to the model.
    task automatic tick();
        bit fire;
        fire = iss_valid && m_iss_ready();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
        end else begin
            if (we3 && a3 != 0) begin m_mem[a3] = wd3; m_busy[a3] = 0; end
            if (fire && iss_rd != 0) m_busy[iss_rd] = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, '0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, '0, 0, 0);
        check_all("reset_state");
        chk("reset_rdy1", 64'(rdy1), 64'd1);
        chk("reset_cnt", 64'(busy_cnt), 64'd0);
        tick();

        // write/read and x0 immunity
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0); check_all("wr_x5"); tick();
        drive(0, 5, 0, 0, 0, '0, 0, 0);           check_all("rd_x5");
        chk("rd_x5_const", 64'(rd1), 64'hDEADBEEF); tick();
        drive(0, 0, 0, 1, 0, 32'h1234, 0, 0);     check_all("wr_x0"); tick();
        drive(0, 0, 0, 0, 0, '0, 0, 0);           check_all("rd_x0");
        chk("rd_x0_const", 64'(rd2), 64'd0); tick();

        // same-cycle bypass
        drive(0, 7, 0, 1, 7, 32'hA5A5A5A5, 0, 0); check_all("bypass");
        chk("bypass_const", 64'(rd1), 64'hA5A5A5A5);
        chk("bypass_rdy1", 64'(rdy1), 64'd1); tick();

        // issue, stall, writeback release
        drive(0, 0, 0, 0, 0, '0, 1, 3);           check_all("iss3"); tick();
        drive(0, 3, 0, 0, 0, '0, 0, 0);           check_all("stall3");
        chk("stall3_cnt", 64'(busy_cnt), 64'd1);
        chk("stall3_rdy1", 64'(rdy1), 64'd0);
        chk("stall3_ready", 64'(iss_ready), 64'd0); tick();
        drive(0, 3, 0, 1, 3, 32'h33, 0, 0);       check_all("wb3");
        chk("wb3_rdy1", 64'(rdy1), 64'd1);
        chk("wb3_ready", 64'(iss_ready), 64'd1); tick();
        drive(0, 0, 0, 0, 0, '0, 0, 0);           check_all("post_wb3");
        chk("post_wb3_cnt", 64'(busy_cnt), 64'd0); tick();

        // set wins over clear on same register
        drive(0, 0, 0, 0, 0, '0, 1, 4);           check_all("iss4"); tick();
        drive(0, 0, 0, 1, 4, 32'h44, 1, 4);       check_all("setwins");
        chk("setwins_ready", 64'(iss_ready), 64'd1); tick();
        drive(0, 4, 0, 0, 0, '0, 0, 0);           check_all("post_setwins");
        chk("setwins_cnt", 64'(busy_cnt), 64'd1);
        chk("setwins_rdy1", 64'(rdy1), 64'd0); tick();
        drive(0, 0, 0, 1, 4, 32'h45, 0, 0);       check_all("clr4"); tick();

        // fill all registers, x0 issue, then reset with competing write
        for (int i = 1; i < NREGS; i++) begin
            drive(0, 0, 0, 0, 0, '0, 1, i); check_all("fill"); tick();
        end
        drive(0, 0, 0, 0, 0, '0, 1, 0);           check_all("iss_x0");
        chk("full_cnt", 64'(busy_cnt), 64'd31); tick();
        drive(0, 0, 0, 0, 0, '0, 0, 0);           check_all("after_x0");
        chk("after_x0_cnt", 64'(busy_cnt), 64'd31); tick();
        drive(1, 0, 0, 1, 9, 32'h99, 1, 0);       tick();
        drive(0, 9, 5, 0, 0, '0, 0, 0);           check_all("post_reset");
        chk("post_reset_rd1", 64'(rd1), 64'd0);
        chk("post_reset_rd2", 64'(rd2), 64'd0);
        chk("post_reset_cnt", 64'(busy_cnt), 64'd0); tick();

        // random traffic, small address range to provoke hazards
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7));
            check_all("rand");
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
